fsm_sequencer: RTL

Controller that drives the serial-input pattern FSM (1-bit in, 2-bit Moore out) from the same clock. Per job it resets the FSM, shifts a WIDTH-bit word into it MSB-first, one bit per cycle, then captures the FSM output. In sweep mode it runs every word 0 .. 2^WIDTH-1 back to back, giving in-system self-check of the FSM.

---
 rtl/fsm_sequencer_if.sv | 49 ++++
 rtl/fsm_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fsm_sequencer_if.sv
// -----------------------------------------------------------------------------
// fsm_sequencer_if
// Job-side interface of the FSM sequencer.
//   master : job requester (drives start/sweep/word, observes status/results)
//   slave  : sequencer     (consumes the request, drives status/results)
// Signals:
//   start     job request, only honoured while the sequencer is idle
//   sweep     0 = single word, 1 = every word 0 .. 2^WIDTH-1
//   word      word for single mode
//   busy      job in progress
//   res_valid one-cycle pulse, result/res_idx valid
//   res_idx   word that produced result
//   result    captured FSM output
//   done      one-cycle pulse alongside the last res_valid of a job
// -----------------------------------------------------------------------------
interface fsm_sequencer_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic             sweep;
  logic [WIDTH-1:0] word;
  logic             busy;
  logic             res_valid;
  logic [WIDTH-1:0] res_idx;
  logic [1:0]       result;
  logic             done;

  modport master (
    output start,
    output sweep,
    output word,
    input  busy,
    input  res_valid,
    input  res_idx,
    input  result,
    input  done
  );

  modport slave (
    input  start,
    input  sweep,
    input  word,
    output busy,
    output res_valid,
    output res_idx,
    output result,
    output done
  );
endinterface

// File: rtl/fsm_sequencer.sv
// -----------------------------------------------------------------------------
// fsm_sequencer
// Drives a serial-input pattern FSM (1-bit in, 2-bit Moore out) on the same
// clock. Per word: hold the FSM in reset, shift the word in MSB-first one bit
// per cycle, then capture the FSM output. Sweep mode walks every word
// 0 .. 2^WIDTH-1 back to back for an in-system self-check of the FSM.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous, active-high reset
//   job      fsm_sequencer_if.slave (start/sweep/word in; busy, res_valid,
//            res_idx, result, done out)
//   fsm_in   serial bit to the FSM, registered
//   fsm_rst  active-high reset to the FSM, registered
//   fsm_out  FSM output, sampled only in CAPTURE
//
// States:
//   state     | meaning
//   S_IDLE    | waiting for start; FSM held in reset
//   S_RST     | FSM held in reset for RST_CYCLES cycles before a word
//   S_SHIFT   | word shifted into the FSM MSB-first, WIDTH cycles
//   S_CAPTURE | one cycle; fsm_out captured at the closing edge
// -----------------------------------------------------------------------------
module fsm_sequencer #(
  parameter int WIDTH      = 3,
  parameter int RST_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  fsm_sequencer_if.slave job,
  output logic           fsm_in,
  output logic           fsm_rst,
  input  logic [1:0]     fsm_out
);

  // One down-counter serves both the reset phase and the shift phase.
  localparam int CNT_MAX = (RST_CYCLES > WIDTH) ? RST_CYCLES : WIDTH;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]    RST_LOAD   = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]    SHIFT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE    = CW'(1);
  localparam logic [WIDTH-1:0] WORD_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] WORD_LAST  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RST,
    S_SHIFT,
    S_CAPTURE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             sweep_q, sweep_d;
  logic             fsm_in_q, fsm_in_d;
  logic             fsm_rst_q, fsm_rst_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic             done_q, done_d;
  logic [1:0]       result_q, result_d;
  logic [WIDTH-1:0] res_idx_q, res_idx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      sh_q        <= '0;
      sweep_q     <= 1'b0;
      fsm_in_q    <= 1'b0;
      fsm_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= 2'b00;
      res_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      sh_q        <= sh_d;
      sweep_q     <= sweep_d;
      fsm_in_q    <= fsm_in_d;
      fsm_rst_q   <= fsm_rst_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
      result_q    <= result_d;
      res_idx_q   <= res_idx_d;
    end
  end

  // fsm_in/fsm_rst are registered, so they are computed here for the state
  // being entered: the value seen in a cycle always matches that cycle's state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    sh_d        = sh_q;
    sweep_d     = sweep_q;
    fsm_in_d    = 1'b0;
    fsm_rst_d   = 1'b1;
    busy_d      = busy_q;
    res_valid_d = 1'b0;
    done_d      = 1'b0;
    result_d    = result_q;
    res_idx_d   = res_idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (job.start) begin
          word_d  = job.sweep ? '0 : job.word;
          sweep_d = job.sweep;
          busy_d  = 1'b1;
          cnt_d   = RST_LOAD;
          state_d = S_RST;
        end
      end

      S_RST: begin
        if (cnt_q == '0) begin
          // Entering SHIFT cycle 0: present the MSB, queue the rest.
          state_d   = S_SHIFT;
          cnt_d     = SHIFT_LOAD;
          fsm_rst_d = 1'b0;
          fsm_in_d  = word_q[WIDTH-1];
          sh_d      = word_q << 1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_SHIFT: begin
        fsm_rst_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d    = cnt_q - CNT_ONE;
          fsm_in_d = sh_q[WIDTH-1];
          sh_d     = sh_q << 1;
        end
      end

      S_CAPTURE: begin
        result_d    = fsm_out;
        res_idx_d   = word_q;
        res_valid_d = 1'b1;
        // Last-word test uses the pre-increment value so a sweep ends at
        // all ones and never wraps back to 0.
        if (!sweep_q || (word_q == WORD_LAST)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          word_d  = word_q + WORD_ONE;
          cnt_d   = RST_LOAD;
          state_d = S_RST;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign fsm_in        = fsm_in_q;
  assign fsm_rst       = fsm_rst_q;
  assign job.busy      = busy_q;
  assign job.res_valid = res_valid_q;
  assign job.done      = done_q;
  assign job.result    = result_q;
  assign job.res_idx   = res_idx_q;

endmodule
